// File: rtl/gpu_types_pkg.sv
// ============================================================================
// Module : gpu_types (package)
// Brief  : Shared GPU core types: the barrier request bundle and sizing helper.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpu_types;

  localparam int GPU_NUM_WARPS    = 4;
  localparam int GPU_NUM_BARRIERS = 4;

  // Index width for n items; a single item still needs one bit of index.
  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int GPU_NW_BITS = bits_for(GPU_NUM_WARPS);
  localparam int GPU_NB_BITS = bits_for(GPU_NUM_BARRIERS);

  typedef struct packed {
    logic                   valid;
    logic [GPU_NB_BITS-1:0] id;
    logic [GPU_NW_BITS-1:0] size_m1;
  } gpu_barrier_t;

  localparam int GPU_BARRIER_BITS = $bits(gpu_barrier_t);

endpackage

`default_nettype wire

// File: rtl/vx_barrier_table.sv
// ============================================================================
// Module : vx_barrier_table
// Brief  : Per-core barrier table; stalls arriving warps and releases them
//          once the last participant arrives.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vx_barrier_table
  import gpu_types::*;
#(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int NW_BITS      = bits_for(NUM_WARPS),
  parameter int NB_BITS      = bits_for(NUM_BARRIERS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic [NW_BITS-1:0]      req_wid,
  input  logic [NB_BITS-1:0]      req_id,
  input  logic [NW_BITS-1:0]      req_size_m1,
  output logic [NUM_WARPS-1:0]    stalled_warps,
  output logic                    release_valid,
  output logic [NB_BITS-1:0]      release_id,
  output logic [NUM_WARPS-1:0]    release_mask,
  output logic [NUM_BARRIERS-1:0] active_barriers
);

  logic [NW_BITS-1:0]   r_cnt  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] r_mask [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] r_stalled;
  logic                 r_rel_valid;
  logic [NB_BITS-1:0]   r_rel_id;
  logic [NUM_WARPS-1:0] r_rel_mask;

  logic                 w_dup;
  logic                 w_fire;
  logic                 w_done;
  logic [NUM_WARPS-1:0] w_wmask;
  logic [NUM_WARPS-1:0] w_rel_mask;

  // A warp already parked on a barrier cannot legally arrive again.
  assign w_dup      = r_stalled[req_wid];
  assign w_fire     = req_valid && !w_dup;
  assign w_done     = w_fire && (r_cnt[req_id] == req_size_m1);
  assign w_wmask    = NUM_WARPS'(1) << req_wid;
  assign w_rel_mask = r_mask[req_id] | w_wmask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        r_cnt[b]  <= '0;
        r_mask[b] <= '0;
      end
      r_stalled   <= '0;
      r_rel_valid <= 1'b0;
      r_rel_id    <= '0;
      r_rel_mask  <= '0;
    end else begin
      r_rel_valid <= w_done;
      r_rel_id    <= w_done ? req_id : '0;
      r_rel_mask  <= w_done ? w_rel_mask : '0;
      if (w_fire) begin
        if (w_done) begin
          r_cnt[req_id]  <= '0;
          r_mask[req_id] <= '0;
          r_stalled      <= r_stalled & ~w_rel_mask;
        end else begin
          r_cnt[req_id]  <= r_cnt[req_id] + NW_BITS'(1);
          r_mask[req_id] <= r_mask[req_id] | w_wmask;
          r_stalled      <= r_stalled | w_wmask;
        end
      end
    end
  end

  generate
    for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_active
      assign active_barriers[b] = |r_mask[b];
    end
  endgenerate

  assign stalled_warps = r_stalled;
  assign release_valid = r_rel_valid;
  assign release_id    = r_rel_id;
  assign release_mask  = r_rel_mask;

  a_no_dup_arrival : assert property (
    @(posedge clk) disable iff (reset) req_valid |-> !w_dup
  ) else $warning("barrier request from already-stalled warp %0d ignored", req_wid);

endmodule

`default_nettype wire

// File: tb/tb_vx_barrier_table.sv
// ============================================================================
// Module : tb_vx_barrier_table
// Brief  : Directed-vector bench for vx_barrier_table (4 warps, 4 barriers).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vx_barrier_table;

  localparam int NW = 4;
  localparam int NB = 4;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic [1:0]    req_wid;
  logic [1:0]    req_id;
  logic [1:0]    req_size_m1;
  logic [NW-1:0] stalled_warps;
  logic          release_valid;
  logic [1:0]    release_id;
  logic [NW-1:0] release_mask;
  logic [NB-1:0] active_barriers;

  int n_checks = 0;
  int n_fail   = 0;

  vx_barrier_table #(.NUM_WARPS(NW), .NUM_BARRIERS(NB)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_wid         (req_wid),
    .req_id          (req_id),
    .req_size_m1     (req_size_m1),
    .stalled_warps   (stalled_warps),
    .release_valid   (release_valid),
    .release_id      (release_id),
    .release_mask    (release_mask),
    .active_barriers (active_barriers)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [1:0]    wid;
    logic [1:0]    id;
    logic [1:0]    sm1;
    logic [NW-1:0] stalled;
    logic          rv;
    logic [1:0]    rid;
    logic [NW-1:0] rmask;
    logic [NB-1:0] active;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [NW-1:0] st, input logic rv,
                       input logic [1:0] rid, input logic [NW-1:0] rm,
                       input logic [NB-1:0] act);
    n_checks++;
    if (stalled_warps !== st || release_valid !== rv || release_id !== rid ||
        release_mask !== rm || active_barriers !== act) begin
      n_fail++;
      $display("FAIL %s: got stalled=%b rv=%b rid=%0d rmask=%b active=%b, want stalled=%b rv=%b rid=%0d rmask=%b active=%b",
               name, stalled_warps, release_valid, release_id, release_mask, active_barriers,
               st, rv, rid, rm, act);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the following rising edge.
  task automatic step(input logic v, input logic [1:0] wid, input logic [1:0] id,
                      input logic [1:0] sm1);
    @(negedge clk);
    req_valid   = v;
    req_wid     = wid;
    req_id      = id;
    req_size_m1 = sm1;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v, input logic [1:0] wid, input logic [1:0] id,
                              input logic [1:0] sm1, input logic [NW-1:0] st,
                              input logic rv, input logic [1:0] rid,
                              input logic [NW-1:0] rm, input logic [NB-1:0] act);
    vec_t r;
    r.v = v; r.wid = wid; r.id = id; r.sm1 = sm1;
    r.stalled = st; r.rv = rv; r.rid = rid; r.rmask = rm; r.active = act;
    return r;
  endfunction

  initial begin
    //              v  wid  id  sm1 stalled  rv rid rmask   active
    vecs[0]  = mk(1, 0, 1, 2, 4'b0001, 0, 0, 4'b0000, 4'b0010);
    vecs[1]  = mk(1, 1, 1, 2, 4'b0011, 0, 0, 4'b0000, 4'b0010);
    vecs[2]  = mk(1, 2, 1, 2, 4'b0000, 1, 1, 4'b0111, 4'b0000);
    vecs[3]  = mk(0, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    vecs[4]  = mk(1, 3, 0, 0, 4'b0000, 1, 0, 4'b1000, 4'b0000);
    vecs[5]  = mk(0, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    vecs[6]  = mk(1, 0, 0, 1, 4'b0001, 0, 0, 4'b0000, 4'b0001);
    vecs[7]  = mk(1, 1, 2, 1, 4'b0011, 0, 0, 4'b0000, 4'b0101);
    vecs[8]  = mk(1, 2, 2, 1, 4'b0001, 1, 2, 4'b0110, 4'b0001);
    vecs[9]  = mk(0, 0, 0, 0, 4'b0001, 0, 0, 4'b0000, 4'b0001);
    vecs[10] = mk(1, 3, 0, 1, 4'b0000, 1, 0, 4'b1001, 4'b0000);
    // size compared against the current request only
    vecs[11] = mk(1, 0, 2, 3, 4'b0001, 0, 0, 4'b0000, 4'b0100);
    vecs[12] = mk(1, 1, 2, 1, 4'b0000, 1, 2, 4'b0011, 4'b0000);
    vecs[13] = mk(0, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    // duplicate arrival from a stalled warp is dropped, cnt stays 1
    vecs[14] = mk(1, 0, 1, 1, 4'b0001, 0, 0, 4'b0000, 4'b0010);
    vecs[15] = mk(1, 0, 1, 1, 4'b0001, 0, 0, 4'b0000, 4'b0010);
    vecs[16] = mk(1, 1, 1, 1, 4'b0000, 1, 1, 4'b0011, 4'b0000);

    reset       = 1'b1;
    req_valid   = 1'b0;
    req_wid     = '0;
    req_id      = '0;
    req_size_m1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 4'b0000, 0, 0, 4'b0000, 4'b0000);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].v, vecs[i].wid, vecs[i].id, vecs[i].sm1);
      check($sformatf("vec%0d", i), vecs[i].stalled, vecs[i].rv, vecs[i].rid,
            vecs[i].rmask, vecs[i].active);
    end

    // Reset with waiters on id3: everything clears at once, no release pulse.
    step(1, 0, 3, 3);
    check("rst_pre_w0", 4'b0001, 0, 0, 4'b0000, 4'b1000);
    step(1, 1, 3, 3);
    check("rst_pre_w1", 4'b0011, 0, 0, 4'b0000, 4'b1000);
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    check("rst_async", 4'b0000, 0, 0, 4'b0000, 4'b0000);
    @(posedge clk);
    #1;
    check("rst_held", 4'b0000, 0, 0, 4'b0000, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 0, 0);
    check("rst_no_pulse", 4'b0000, 0, 0, 4'b0000, 4'b0000);
    step(1, 2, 3, 1);
    check("post_rst_fresh", 4'b0100, 0, 0, 4'b0000, 4'b1000);
    step(1, 3, 3, 1);
    check("post_rst_cnt1", 4'b0000, 1, 3, 4'b1100, 4'b0000);

    // Asynchronous reset while a release pulse is showing.
    step(1, 0, 2, 0);
    check("pulse_pre_rst", 4'b0000, 1, 2, 4'b0001, 4'b0000);
    #2;
    reset = 1'b1;
    #1;
    check("pulse_rst_clear", 4'b0000, 0, 0, 4'b0000, 4'b0000);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    step(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vx_barrier_table.md
VX_BARRIER_TABLE -- requirements
Module: VX_barrier_table

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4: warps per core; NW_BITS = max(1, clog2(NUM_WARPS)).
REQ-002 SHALL have parameter NUM_BARRIERS, default 4: barrier slots; NB_BITS = max(1, clog2(NUM_BARRIERS)).
REQ-003 SHALL have one clock, clk, and an asynchronous, active-high reset, reset.
REQ-004 clk  input  1  core clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  1  barrier arrival from the GPU unit (gpu_barrier_t valid).
REQ-007 req_wid  input  NW_BITS  arriving warp id.
REQ-008 req_id  input  NB_BITS  barrier id (gpu_barrier_t id).
REQ-009 req_size_m1  input  NW_BITS  participating warps minus one (gpu_barrier_t size_m1).
REQ-010 stalled_warps  output  NUM_WARPS  per-warp barrier stall, to the warp scheduler.
REQ-011 release_valid  output  1  one-cycle pulse: a barrier completed.
REQ-012 release_id  output  NB_BITS  id of the completed barrier.
REQ-013 release_mask  output  NUM_WARPS  warps freed by the completion.
REQ-014 active_barriers  output  NUM_BARRIERS  bit b set while barrier b has at least one waiter.

Function
REQ-015 SHALL hold, per barrier b: cnt[b] (NW_BITS, number of waiting warps) and mask[b] (NUM_WARPS, waiting-warp set).
REQ-016 SHALL accept one request per cycle with no backpressure; each request is consumed in its cycle.
REQ-017 Arrival (req_valid, cnt[req_id] != req_size_m1) SHALL, next edge: cnt += 1, set mask[req_id][req_wid], set stalled_warps[req_wid].
REQ-018 Completion (req_valid, cnt[req_id] == req_size_m1) SHALL, next edge: clear cnt and mask of req_id, clear stalled_warps bits in (mask[req_id] | onehot(req_wid)), and register release_valid=1, release_id=req_id, release_mask=mask[req_id] | onehot(req_wid).
REQ-019 Completion latency SHALL be one cycle: stall bits drop on the same edge on which release_valid rises.
REQ-020 req_size_m1 = 0 SHALL complete immediately: the requesting warp is never stalled, and release_mask is that warp only.
REQ-021 Completion compare SHALL use the req_size_m1 of the current request; earlier size values are not stored.
REQ-022 release_valid SHALL be low in every cycle not directly following a completion; release_id and release_mask SHALL be zero when release_valid is low.
REQ-023 active_barriers[b] SHALL equal |mask[b]| (combinational from registered state).
REQ-024 Barriers SHALL be independent; a request touches only slot req_id.
REQ-025 A request from a warp already set in stalled_warps SHALL be ignored (no state change) and flagged by a simulation-only assertion.
REQ-026 Incrementing cnt SHALL never wrap, given REQ-025 and size_m1 < NUM_WARPS.

Reset
REQ-027 Reset SHALL clear all cnt, mask, stalled_warps, release_valid, release_id and release_mask to zero, asynchronously.
REQ-028 Reset mid-barrier SHALL discard all waiters with no release pulse; the first request after deassertion is treated as a fresh arrival.

Structure
REQ-029 gpu_barrier_t and GPU_BARRIER_BITS SHALL remain in package gpu_types; no new typedef is required.
REQ-030 The per-barrier cnt and mask registers SHALL be a single flat array in this module; no sub-module is required.

Verification
REQ-031 NUM_WARPS=4: id=1, size_m1=2, warps 0,1,2 on consecutive cycles -> stalled=0001, then 0011, then 0000 with release_valid=1, release_id=1, release_mask=0111.
REQ-032 id=0 size_m1=0, wid=3 -> stalled stays 0000; next cycle release_mask=1000.
REQ-033 Interleave warp0→id0 and warp1→id2 (size_m1=1), then warp2→id2 -> only id2 releases (mask 0110); warp0 stays stalled; active_barriers=0001.
REQ-034 Warp0→id1 (size_m1=1), then warp0→id1 again -> second request ignored, assertion fires, cnt[1]=1.
REQ-035 Warps 0,1 waiting on id3 (size_m1=3), assert reset -> all outputs 0 immediately, no release pulse; warp2→id3 afterwards gives cnt=1.
